// File: rtl/aux_input_conditioner.sv
// Board-input front end: synchronises and debounces the slide switches and the resume button.
// Optional auto-repeat of resume_pulse while resume is held is enabled by AUX_INPUT_AUTOREPEAT_EN.
module aux_input_conditioner #(
  parameter int SwtBit      = 16,
  parameter int DebounceCnt = 1000000,
  parameter int RepeatCnt   = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SwtBit-1:0] swt_raw,
  input  logic              resume_raw,
  output logic [SwtBit-1:0] swt,
  output logic              swt_changed,
  output logic              resume,
  output logic              resume_pulse
);

  localparam int CntW = $clog2(DebounceCnt) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCnt - 1);

  logic [SwtBit-1:0] swt_s1_q, swt_s1_d;
  logic [SwtBit-1:0] swt_s2_q, swt_s2_d;
  logic [SwtBit-1:0] swt_last_q, swt_last_d;
  logic [CntW-1:0]   swt_cnt_q, swt_cnt_d;
  logic [SwtBit-1:0] swt_q, swt_d;
  logic              swt_changed_q, swt_changed_d;

  logic              res_s1_q, res_s1_d;
  logic              res_s2_q, res_s2_d;
  logic              res_last_q, res_last_d;
  logic [CntW-1:0]   res_cnt_q, res_cnt_d;
  logic              resume_q, resume_d;
  logic              resume_pulse_q, resume_pulse_d;

  // Switch group: any bit toggle restarts the shared stability count.
  always_comb begin
    swt_s1_d      = swt_raw;
    swt_s2_d      = swt_s1_q;
    swt_last_d    = swt_last_q;
    swt_cnt_d     = swt_cnt_q;
    swt_d         = swt_q;
    swt_changed_d = 1'b0;
    if (swt_s2_q != swt_last_q) begin
      swt_last_d = swt_s2_q;
      swt_cnt_d  = '0;
    end else if (swt_cnt_q == CntMax) begin
      swt_d         = swt_last_q;
      swt_changed_d = (swt_last_q != swt_q);
    end else begin
      swt_cnt_d = swt_cnt_q + 1'b1;
    end
  end

  always_comb begin
    res_s1_d   = resume_raw;
    res_s2_d   = res_s1_q;
    res_last_d = res_last_q;
    res_cnt_d  = res_cnt_q;
    resume_d   = resume_q;
    if (res_s2_q != res_last_q) begin
      res_last_d = res_s2_q;
      res_cnt_d  = '0;
    end else if (res_cnt_q == CntMax) begin
      resume_d = res_last_q;
    end else begin
      res_cnt_d = res_cnt_q + 1'b1;
    end
  end

`ifdef AUX_INPUT_AUTOREPEAT_EN
  localparam int RepW = $clog2(RepeatCnt) + 1;
  localparam logic [RepW-1:0] RepMax = RepW'(RepeatCnt - 1);

  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;

  // Repeat count is 0 in the cycle of the initial pulse; a wrap only fires if resume stays high.
  always_comb begin
    rep_cnt_d      = '0;
    resume_pulse_d = resume_d & ~resume_q;
    if (resume_q) begin
      rep_cnt_d = (rep_cnt_q == RepMax) ? '0 : rep_cnt_q + 1'b1;
      if (resume_d && (rep_cnt_q == RepMax)) begin
        resume_pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`else
  always_comb begin
    resume_pulse_d = resume_d & ~resume_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      swt_s1_q       <= '0;
      swt_s2_q       <= '0;
      swt_last_q     <= '0;
      swt_cnt_q      <= '0;
      swt_q          <= '0;
      swt_changed_q  <= 1'b0;
      res_s1_q       <= 1'b0;
      res_s2_q       <= 1'b0;
      res_last_q     <= 1'b0;
      res_cnt_q      <= '0;
      resume_q       <= 1'b0;
      resume_pulse_q <= 1'b0;
    end else begin
      swt_s1_q       <= swt_s1_d;
      swt_s2_q       <= swt_s2_d;
      swt_last_q     <= swt_last_d;
      swt_cnt_q      <= swt_cnt_d;
      swt_q          <= swt_d;
      swt_changed_q  <= swt_changed_d;
      res_s1_q       <= res_s1_d;
      res_s2_q       <= res_s2_d;
      res_last_q     <= res_last_d;
      res_cnt_q      <= res_cnt_d;
      resume_q       <= resume_d;
      resume_pulse_q <= resume_pulse_d;
    end
  end

  assign swt          = swt_q;
  assign swt_changed  = swt_changed_q;
  assign resume       = resume_q;
  assign resume_pulse = resume_pulse_q;

endmodule
